// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge event arbiter.
package edge_evt_pkg;

  localparam int unsigned MAX_CH   = 8;
  localparam int unsigned CH_IDX_W = $clog2(MAX_CH);

  // Edges are masked until the synchronizer has flushed the post-reset level.
  localparam logic [1:0] WARMUP_CYC = 2'd3;

  typedef enum logic {
    StIdle  = 1'b0,
    StOffer = 1'b1
  } evt_state_e;

endpackage

// File: rtl/edge_sync_det.sv
// One channel of input conditioning: 2-FF synchronizer, history FF and registered edge pulses.
// The falling-edge output exists only when EDGE_FALLING_EN is defined.
module edge_sync_det (
  input  logic clk_100m,
  input  logic reset_n,
  input  logic i_sig,
  input  logic i_arm,
`ifdef EDGE_FALLING_EN
  output logic o_fall,
`endif
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;
  logic r_rise;
`ifdef EDGE_FALLING_EN
  logic r_fall;
`endif

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_rise  <= 1'b0;
`ifdef EDGE_FALLING_EN
      r_fall  <= 1'b0;
`endif
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_rise  <= i_arm & r_sync2 & ~r_hist;
`ifdef EDGE_FALLING_EN
      r_fall  <= i_arm & ~r_sync2 & r_hist;
`endif
    end
  end

  assign o_rise = r_rise;
`ifdef EDGE_FALLING_EN
  assign o_fall = r_fall;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Timestamps edges on N_CH async pulse lines and offers them one at a time, round-robin,
// over a valid/ready port. Define EDGE_FALLING_EN to also report falling edges.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned TS_W = 32
) (
  input  logic                clk_100m,
  input  logic                reset_n,
  input  logic [N_CH-1:0]     sig,
  input  logic [N_CH-1:0]     ch_en,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_IDX_W-1:0] evt_ch,
  output logic                evt_pol,
  output logic [TS_W-1:0]     evt_ts,
  output logic [N_CH-1:0]     ovf,
  input  logic [N_CH-1:0]     ovf_clr
);

`ifdef EDGE_FALLING_EN
  localparam int unsigned POLS = 2;
`else
  localparam int unsigned POLS = 1;
`endif
  // Requester j belongs to channel j/POLS; with falling edges, even j is rising, odd j falling.
  localparam int unsigned N_REQ = N_CH * POLS;
  localparam int unsigned REQ_W = $clog2(N_REQ);
  localparam logic [REQ_W-1:0] LAST_REQ = REQ_W'(N_REQ - 1);

  evt_state_e          r_state;
  logic [1:0]          r_warm;
  logic                w_arm;
  logic [TS_W-1:0]     r_cnt;
  logic [N_REQ-1:0]    r_pend;
  logic [TS_W-1:0]     r_ts [N_REQ];
  logic [N_REQ-1:0]    w_edge, w_en_req, w_hit, w_req, w_offered, w_clr, w_ovf_req;
  logic [N_CH-1:0]     w_ovf_set, r_ovf;
  logic [REQ_W-1:0]    r_rr, r_sel, w_gnt, w_gnt_nxt;
  logic                w_any, w_gnt_pol;
  logic [CH_IDX_W-1:0] w_gnt_ch, r_ch;
  logic                r_valid, r_pol;
  logic [TS_W-1:0]     r_evt_ts;

  assign w_arm = (r_warm == WARMUP_CYC);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
`ifdef EDGE_FALLING_EN
    edge_sync_det u_det (
      .clk_100m (clk_100m),
      .reset_n  (reset_n),
      .i_sig    (sig[c]),
      .i_arm    (w_arm),
      .o_fall   (w_edge[2*c+1]),
      .o_rise   (w_edge[2*c])
    );
`else
    edge_sync_det u_det (
      .clk_100m (clk_100m),
      .reset_n  (reset_n),
      .i_sig    (sig[c]),
      .i_arm    (w_arm),
      .o_rise   (w_edge[c])
    );
`endif
  end

  always_comb begin
    w_en_req  = '0;
    w_offered = '0;
    w_clr     = '0;
    w_ovf_set = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      w_en_req[j]  = ch_en[j / POLS];
      w_offered[j] = (r_state == StOffer) && (r_sel == REQ_W'(j));
      w_clr[j]     = w_offered[j] && evt_ready;
    end
    w_hit     = w_edge & w_en_req;
    w_req     = r_pend & w_en_req;
    w_ovf_req = w_hit & r_pend & ~w_clr;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      w_ovf_set[j / POLS] = w_ovf_set[j / POLS] | w_ovf_req[j];
    end
  end

  // Round-robin: first pending requester at or above r_rr, wrapping.
  always_comb begin
    int unsigned v_idx;
    logic [REQ_W-1:0] v_cand;
    w_any  = 1'b0;
    w_gnt  = '0;
    v_idx  = 0;
    v_cand = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      v_idx = 32'(r_rr) + k;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      v_cand = REQ_W'(v_idx);
      if (!w_any && w_req[v_cand]) begin
        w_any = 1'b1;
        w_gnt = v_cand;
      end
    end
  end

  assign w_gnt_nxt = (w_gnt == LAST_REQ) ? '0 : w_gnt + 1'b1;
  assign w_gnt_ch  = CH_IDX_W'(w_gnt / POLS);
`ifdef EDGE_FALLING_EN
  assign w_gnt_pol = ~w_gnt[0];
`else
  assign w_gnt_pol = 1'b1;
`endif

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_warm <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
      for (int unsigned j = 0; j < N_REQ; j++) r_ts[j] <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (!w_arm) r_warm <= r_warm + 1'b1;
      r_ovf <= (r_ovf | w_ovf_set) & ~ovf_clr;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!w_en_req[j] && !w_offered[j]) begin
          r_pend[j] <= 1'b0;
        end else if (w_hit[j]) begin
          r_pend[j] <= 1'b1;
          // An overflowing edge keeps the first timestamp; a same-cycle accept frees the slot.
          if (!r_pend[j] || w_clr[j]) r_ts[j] <= r_cnt;
        end else if (w_clr[j]) begin
          r_pend[j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_rr     <= '0;
      r_sel    <= '0;
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_pol    <= 1'b0;
      r_evt_ts <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_state  <= StOffer;
            r_valid  <= 1'b1;
            r_sel    <= w_gnt;
            r_rr     <= w_gnt_nxt;
            r_ch     <= w_gnt_ch;
            r_pol    <= w_gnt_pol;
            r_evt_ts <= r_ts[w_gnt];
          end
        end
        StOffer: begin
          if (evt_ready) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign evt_valid = r_valid;
  assign evt_ch    = r_ch;
  assign evt_pol   = r_pol;
  assign evt_ts    = r_evt_ts;
  assign ovf       = r_ovf;

endmodule
